decryption_regfile: RTL and testbench
=====================================

# decryption_regfile

Configuration register file for the decryption engine. It holds the algorithm select code and the three cipher keys (Caesar, Scytale, ZigZag), and drives them continuously to the decryption datapath. The block exposes a simple single-cycle read/write access port that acknowledges each access with a one-cycle `done` pulse and flags unmapped addresses with `error`.

## Interface
- `ADDR_WIDTH`, 8, access address width
- `REG_WIDTH`, 16, data and key width
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `addr` input ADDR_WIDTH: access address, sampled when `read` or `write` is high.
- `read` input 1: read request, one-cycle pulse.
- `write` input 1: write request, one-cycle pulse.
- `wdata` input REG_WIDTH: write data, sampled with `write`.
- `rdata` output REG_WIDTH: read data, valid while `done` is high; 0 otherwise.
- `done` output 1: access acknowledge, one-cycle pulse per access.
- `error` output 1: access to an unmapped address, valid only with `done`.
- `select` output REG_WIDTH: algorithm select, `{14'b0, sel[1:0]}`.
- `caesar_key` output REG_WIDTH: Caesar key register.
- `scytale_key` output REG_WIDTH: Scytale key register.
- `zigzag_key` output REG_WIDTH: ZigZag key register.

## Operation
- Register map (exact address match; every other address is unmapped):
  - 0x00: select. Only bits [1:0] are stored; writes ignore bits [15:2]; reads return `{14'b0, sel}`. Reset value 0x0000.
  - 0x10: caesar_key. Full 16 bits. Reset value 0x0000.
  - 0x12: scytale_key. Full 16 bits. Reset value 0xFFFF.
  - 0x14: zigzag_key. Full 16 bits. Reset value 0x0002.
- Write to a mapped address: the register is updated at the sampling edge. `done`=1, `error`=0, `rdata`=0 in the next cycle.
- Read of a mapped address: `rdata` is the register value and `done`=1, `error`=0 in the next cycle. Registers are unchanged.
- Access to an unmapped address (read or write): no register changes. `done`=1, `error`=1, `rdata`=0 in the next cycle.
- `read` and `write` both high in the same cycle: handled as a write (write has priority). Exactly one `done` pulse is produced.
- No request in a cycle: `done`, `error` and `rdata` are 0 in the next cycle.
- Key outputs are the register contents directly, with no extra pipeline stage.
- Reset values of all outputs: `rdata`=0, `done`=0, `error`=0, `select`=0x0000, `caesar_key`=0x0000, `scytale_key`=0xFFFF, `zigzag_key`=0x0002.

## Timing
- Requests are sampled at rising edge N. `done`, `error` and `rdata` are registered and valid during cycle N+1, for exactly one cycle.
- Latency is fixed at 1 cycle for every access type. There is no wait state and no backpressure.
- Back-to-back requests on consecutive cycles are each acknowledged one cycle later. `done` stays high across consecutive accesses.
- A written value is visible on the key/select outputs from cycle N+1 onward, and on a read issued at edge N+1 or later.
- Reset has priority over any access in the same cycle. An access sampled in the reset cycle is dropped and produces no `done`.
- If reset is asserted in the cycle after a request, the pending `done`/`error`/`rdata` are forced to 0 and all registers return to their reset values.

## Test plan
- Reset then read 0x00, 0x10, 0x12, 0x14 -> `rdata` = 0x0000, 0x0000, 0xFFFF, 0x0002; each with `done`=1, `error`=0 one cycle after the request.
- Write 0x10 = 0x0003, then read 0x10 -> `caesar_key`=0x0003 from the cycle after the write; read returns 0x0003.
- Write 0x00 = 0xFFFE -> `select`=0x0002; reading 0x00 returns 0x0002.
- Read 0x11 and write 0x20 = 0x1234 -> `done`=1, `error`=1, `rdata`=0; all key and select outputs are unchanged.
- Back-to-back: write 0x12 = 0x0005, then read 0x12 on the next cycle -> `done` high for two cycles; the read returns 0x0005.
- Write 0x14 = 0x0007, then assert `rst` for one cycle -> `zigzag_key` returns to 0x0002; `done`=0.

Source files
------------

// File: rtl/decryption_regfile_if.sv
// Access bus of the decryption config register file: single-cycle request,
// registered done/error/rdata response one cycle later.
interface decryption_regfile_if #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned RegWidth  = 16
);
  logic [AddrWidth-1:0] addr;
  logic                 read;
  logic                 write;
  logic [RegWidth-1:0]  wdata;
  logic [RegWidth-1:0]  rdata;
  logic                 done;
  logic                 error;

  modport master (
    output addr, read, write, wdata,
    input  rdata, done, error
  );

  modport slave (
    input  addr, read, write, wdata,
    output rdata, done, error
  );
endinterface

// File: rtl/decryption_regfile.sv
// Config registers (algorithm select + Caesar/Scytale/ZigZag keys) for the
// decryption engine, with a 1-cycle-latency read/write access port.
module decryption_regfile #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned RegWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  decryption_regfile_if.slave bus,
  output logic [RegWidth-1:0] select_o,
  output logic [RegWidth-1:0] caesar_key_o,
  output logic [RegWidth-1:0] scytale_key_o,
  output logic [RegWidth-1:0] zigzag_key_o
);

  localparam logic [AddrWidth-1:0] AddrSel     = AddrWidth'(8'h00);
  localparam logic [AddrWidth-1:0] AddrCaesar  = AddrWidth'(8'h10);
  localparam logic [AddrWidth-1:0] AddrScytale = AddrWidth'(8'h12);
  localparam logic [AddrWidth-1:0] AddrZigzag  = AddrWidth'(8'h14);

  localparam logic [RegWidth-1:0] RstCaesar  = RegWidth'(16'h0000);
  localparam logic [RegWidth-1:0] RstScytale = RegWidth'(16'hFFFF);
  localparam logic [RegWidth-1:0] RstZigzag  = RegWidth'(16'h0002);

  logic [1:0]          sel_q, sel_d;
  logic [RegWidth-1:0] caesar_q, caesar_d;
  logic [RegWidth-1:0] scytale_q, scytale_d;
  logic [RegWidth-1:0] zigzag_q, zigzag_d;
  logic [RegWidth-1:0] rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [RegWidth-1:0] sel_ext;
  assign sel_ext = {{(RegWidth-2){1'b0}}, sel_q};

  // Write wins over read when both are requested in the same cycle.
  always_comb begin
    sel_d     = sel_q;
    caesar_d  = caesar_q;
    scytale_d = scytale_q;
    zigzag_d  = zigzag_q;
    rdata_d   = '0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    if (bus.write) begin
      done_d = 1'b1;
      case (bus.addr)
        AddrSel:     sel_d     = bus.wdata[1:0];
        AddrCaesar:  caesar_d  = bus.wdata;
        AddrScytale: scytale_d = bus.wdata;
        AddrZigzag:  zigzag_d  = bus.wdata;
        default:     error_d   = 1'b1;
      endcase
    end else if (bus.read) begin
      done_d = 1'b1;
      case (bus.addr)
        AddrSel:     rdata_d = sel_ext;
        AddrCaesar:  rdata_d = caesar_q;
        AddrScytale: rdata_d = scytale_q;
        AddrZigzag:  rdata_d = zigzag_q;
        default:     error_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q     <= 2'b00;
      caesar_q  <= RstCaesar;
      scytale_q <= RstScytale;
      zigzag_q  <= RstZigzag;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      caesar_q  <= caesar_d;
      scytale_q <= scytale_d;
      zigzag_q  <= zigzag_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign select_o      = sel_ext;
  assign caesar_key_o  = caesar_q;
  assign scytale_key_o = scytale_q;
  assign zigzag_key_o  = zigzag_q;

endmodule

// File: tb/tb_decryption_regfile.sv
// Directed vector bench for decryption_regfile: table of accesses with
// hand-computed responses, plus reset-interaction sequences.
module tb_decryption_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] select_o, caesar_key_o, scytale_key_o, zigzag_key_o;

  int total = 0;
  int bad   = 0;

  decryption_regfile_if #(.AddrWidth(8), .RegWidth(16)) bus ();

  decryption_regfile #(
    .AddrWidth(8),
    .RegWidth (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .select_o     (select_o),
    .caesar_key_o (caesar_key_o),
    .scytale_key_o(scytale_key_o),
    .zigzag_key_o (zigzag_key_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] exp_sel;
    logic [15:0] exp_caesar;
    logic [15:0] exp_scytale;
    logic [15:0] exp_zigzag;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic dn, input logic er, input logic [15:0] rd,
                         input logic [15:0] sl, input logic [15:0] ck, input logic [15:0] sk,
                         input logic [15:0] zk);
    chk({tag, " done"}, {15'b0, bus.done}, {15'b0, dn});
    chk({tag, " error"}, {15'b0, bus.error}, {15'b0, er});
    chk({tag, " rdata"}, bus.rdata, rd);
    chk({tag, " select"}, select_o, sl);
    chk({tag, " caesar"}, caesar_key_o, ck);
    chk({tag, " scytale"}, scytale_key_o, sk);
    chk({tag, " zigzag"}, zigzag_key_o, zk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
    bus.read  = rd;
    bus.write = wr;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  initial begin
    //              rd    wr    addr   wdata    done  err   rdata    sel      caesar   scytale  zigzag
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002};
    vecs[1]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002};
    vecs[2]  = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002};
    vecs[3]  = '{1'b1, 1'b0, 8'h14, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002};
    vecs[4]  = '{1'b0, 1'b1, 8'h10, 16'h0003, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[5]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 16'hFFFE, 1'b1, 1'b0, 16'h0000, 16'h0002, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0002, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[8]  = '{1'b1, 1'b0, 8'h11, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0002, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[9]  = '{1'b0, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 16'h0000, 16'h0002, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[10] = '{1'b0, 1'b0, 8'h10, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0003, 16'hFFFF, 16'h0002};
    vecs[11] = '{1'b0, 1'b1, 8'h12, 16'h0005, 1'b1, 1'b0, 16'h0000, 16'h0002, 16'h0003, 16'h0005, 16'h0002};
    vecs[12] = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0002, 16'h0003, 16'h0005, 16'h0002};
    vecs[13] = '{1'b1, 1'b1, 8'h14, 16'h0009, 1'b1, 1'b0, 16'h0000, 16'h0002, 16'h0003, 16'h0005, 16'h0009};
    vecs[14] = '{1'b1, 1'b0, 8'h14, 16'h0000, 1'b1, 1'b0, 16'h0009, 16'h0002, 16'h0003, 16'h0005, 16'h0009};
    vecs[15] = '{1'b0, 1'b1, 8'h11, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'h0002, 16'h0003, 16'h0005, 16'h0009};

    drive(1'b0, 1'b0, 8'h00, 16'h0000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002);

    @(negedge clk);
    rst = 1'b0;

    // Consecutive vectors are issued back-to-back, one per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_rdata,
              vecs[i].exp_sel, vecs[i].exp_caesar, vecs[i].exp_scytale, vecs[i].exp_zigzag);
      @(negedge clk);
    end

    // Write zigzag, then reset in the following cycle clears pending done and registers.
    drive(1'b0, 1'b1, 8'h14, 16'h0007);
    @(posedge clk);
    #1;
    chk_all("zz_wr", 1'b1, 1'b0, 16'h0000, 16'h0002, 16'h0003, 16'h0005, 16'h0007);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 16'h0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_after_wr", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002);

    // Access sampled during reset is dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h10, 16'h00AB);
    @(posedge clk);
    #1;
    chk_all("wr_in_rst", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h10, 16'h0000);
    @(posedge clk);
    #1;
    chk_all("rd_after_rst", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 16'h0000);
    @(posedge clk);
    #1;
    chk_all("idle_end", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
